// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline: register file with WB bypass,
// control decode, load-use / branch-operand hazard detection and branch/jump resolution.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_write_reg,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_write_reg,
  output logic [2:0]  alu_function,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] sign_extend,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] addPC,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic [1:0]  pc_src,
  output logic [31:0] pc_target
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] regs [32];
  logic [31:0] rd1_raw;
  logic [31:0] rd2_raw;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign sign_extend = {{16{instr[15]}}, instr[15:0]};
  assign addPC       = pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_reg_write && wb_write_reg != 5'd0) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  // Reads see a same-cycle WB write; r0 is hardwired to zero.
  always_comb begin
    rd1_raw = regs[rs];
    rd2_raw = regs[rt];
    if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == rs) rd1_raw = wb_write_data;
    if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == rt) rd2_raw = wb_write_data;
    if (rs == 5'd0) rd1_raw = '0;
    if (rt == 5'd0) rd2_raw = '0;
  end

  assign read_data1 = rst ? '0 : rd1_raw;
  assign read_data2 = rst ? '0 : rd2_raw;

  logic [2:0] dec_alu;
  logic       dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
  logic [1:0] dec_reg_dst, dec_mem_to_reg;
  logic       is_beq, is_bne, is_j, is_jal, is_jr, reads_rt;

  always_comb begin
    dec_alu        = ALU_AND;
    dec_alu_src    = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_dst    = 2'b00;
    dec_mem_to_reg = 2'b00;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    is_j           = 1'b0;
    is_jal         = 1'b0;
    is_jr          = 1'b0;
    reads_rt       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (funct)
          6'b100000: begin dec_alu = ALU_ADD; dec_reg_write = 1'b1; dec_reg_dst = 2'b01; end
          6'b100010: begin dec_alu = ALU_SUB; dec_reg_write = 1'b1; dec_reg_dst = 2'b01; end
          6'b100100: begin dec_alu = ALU_AND; dec_reg_write = 1'b1; dec_reg_dst = 2'b01; end
          6'b100101: begin dec_alu = ALU_OR;  dec_reg_write = 1'b1; dec_reg_dst = 2'b01; end
          6'b101010: begin dec_alu = ALU_SLT; dec_reg_write = 1'b1; dec_reg_dst = 2'b01; end
          6'b001000: is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_LW: begin
        dec_alu = ALU_ADD; dec_alu_src = 1'b1; dec_mem_read = 1'b1;
        dec_reg_write = 1'b1; dec_mem_to_reg = 2'b01;
      end
      OP_SW: begin
        dec_alu = ALU_ADD; dec_alu_src = 1'b1; dec_mem_write = 1'b1; reads_rt = 1'b1;
      end
      OP_ADDI: begin dec_alu = ALU_ADD; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      OP_SLTI: begin dec_alu = ALU_SLT; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1; reads_rt = 1'b1; end
      OP_BNE:  begin is_bne = 1'b1; reads_rt = 1'b1; end
      OP_J:    is_j = 1'b1;
      OP_JAL: begin
        is_jal = 1'b1; dec_reg_write = 1'b1; dec_reg_dst = 2'b10; dec_mem_to_reg = 2'b10;
      end
      default: ;
    endcase
  end

  logic is_branch, load_use, ex_br_hazard, mem_br_hazard, stall, taken;

  assign is_branch = is_beq | is_bne;
  assign load_use  = ex_mem_read && ex_write_reg != 5'd0 &&
                     (ex_write_reg == rs || (reads_rt && ex_write_reg == rt));
  assign ex_br_hazard  = ex_reg_write && ex_write_reg != 5'd0 &&
                         (ex_write_reg == rs || (is_branch && ex_write_reg == rt));
  assign mem_br_hazard = mem_mem_read && mem_write_reg != 5'd0 &&
                         (mem_write_reg == rs || (is_branch && mem_write_reg == rt));
  // Reset must never hold the upstream stages, so it masks every stall source.
  assign stall = !rst && (load_use || ((is_branch || is_jr) && (ex_br_hazard || mem_br_hazard)));
  assign taken = (is_beq && read_data1 == read_data2) || (is_bne && read_data1 != read_data2);

  always_comb begin
    alu_function = dec_alu;
    alu_src      = dec_alu_src;
    reg_write    = dec_reg_write;
    mem_read     = dec_mem_read;
    mem_write    = dec_mem_write;
    reg_dst      = dec_reg_dst;
    mem_to_reg   = dec_mem_to_reg;
    pc_write     = !stall;
    if_id_write  = !stall;
    pc_src       = 2'b00;
    if_id_flush  = 1'b0;
    pc_target    = pc_plus4;
    if (is_branch)        pc_target = pc_plus4 + {sign_extend[29:0], 2'b00};
    else if (is_j || is_jal) pc_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (is_jr)       pc_target = read_data1;
    if (rst || stall) begin
      alu_function = 3'b000;
      alu_src      = 1'b0;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_dst      = 2'b00;
      mem_to_reg   = 2'b00;
    end else begin
      if (taken)               begin pc_src = 2'b01; if_id_flush = 1'b1; end
      else if (is_j || is_jal) begin pc_src = 2'b10; if_id_flush = 1'b1; end
      else if (is_jr)          begin pc_src = 2'b11; if_id_flush = 1'b1; end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: vector table for decode/hazard/redirect plus
// hand-written sequences for reset, register-file bypass and multi-cycle stalls.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc_plus4;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_mem_read, ex_reg_write, mem_mem_read;
  logic [4:0]  ex_write_reg, mem_write_reg;
  logic [2:0]  alu_function;
  logic        alu_src, reg_write, mem_read, mem_write;
  logic [1:0]  reg_dst, mem_to_reg, pc_src;
  logic [31:0] read_data1, read_data2, sign_extend, addPC, pc_target;
  logic [4:0]  rs, rt, rd;
  logic        pc_write, if_id_write, if_id_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_plus4(pc_plus4),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
    .alu_function(alu_function), .alu_src(alu_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .read_data1(read_data1), .read_data2(read_data2), .sign_extend(sign_extend),
    .rs(rs), .rt(rt), .rd(rd), .addPC(addPC), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .pc_src(pc_src), .pc_target(pc_target)
  );

  // Control word layout: {alu_function, alu_src, reg_write, mem_read, mem_write, reg_dst, mem_to_reg}
  localparam logic [10:0] C_NONE = 11'b000_0_0_0_0_00_00;
  localparam logic [10:0] C_ADD  = 11'b010_0_1_0_0_01_00;
  localparam logic [10:0] C_SUB  = 11'b110_0_1_0_0_01_00;
  localparam logic [10:0] C_AND  = 11'b000_0_1_0_0_01_00;
  localparam logic [10:0] C_OR   = 11'b001_0_1_0_0_01_00;
  localparam logic [10:0] C_SLT  = 11'b111_0_1_0_0_01_00;
  localparam logic [10:0] C_LW   = 11'b010_1_1_1_0_00_01;
  localparam logic [10:0] C_SW   = 11'b010_1_0_0_1_00_00;
  localparam logic [10:0] C_ADDI = 11'b010_1_1_0_0_00_00;
  localparam logic [10:0] C_SLTI = 11'b111_1_1_0_0_00_00;
  localparam logic [10:0] C_JAL  = 11'b000_0_1_0_0_10_10;
  localparam logic [10:0] M_ALL  = 11'h7FF;
  localparam logic [10:0] M_WR   = 11'h07F;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        ex_mr, ex_rw;
    logic [4:0]  ex_wr;
    logic        mem_mr;
    logic [4:0]  mem_wr;
    logic [10:0] ctrl;
    logic [10:0] mask;
    logic [1:0]  src;
    logic        pcw;
    logic        flush;
    logic        chk_t;
    logic [31:0] target;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'b000000, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  task automatic add_vec(input logic [31:0] i, input logic [31:0] p,
                         input logic emr, input logic erw, input logic [4:0] ewr,
                         input logic mmr, input logic [4:0] mwr,
                         input logic [10:0] c, input logic [10:0] m, input logic [1:0] s,
                         input logic pw, input logic fl, input logic ct, input logic [31:0] tg);
    vec_t v;
    v.instr = i; v.pc4 = p; v.ex_mr = emr; v.ex_rw = erw; v.ex_wr = ewr;
    v.mem_mr = mmr; v.mem_wr = mwr; v.ctrl = c; v.mask = m; v.src = s;
    v.pcw = pw; v.flush = fl; v.chk_t = ct; v.target = tg;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p,
                               input logic emr, input logic erw, input logic [4:0] ewr,
                               input logic mmr, input logic [4:0] mwr);
    instr = i; pc_plus4 = p;
    ex_mem_read = emr; ex_reg_write = erw; ex_write_reg = ewr;
    mem_mem_read = mmr; mem_write_reg = mwr;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    wb_reg_write = 1'b1; wb_write_reg = r; wb_write_data = d;
    @(posedge clk);
    #1;
    wb_reg_write = 1'b0;
  endtask

  function automatic logic [31:0] ctrl_word();
    return {21'd0, alu_function, alu_src, reg_write, mem_read, mem_write, reg_dst, mem_to_reg};
  endfunction

  initial begin
    rst = 1'b1;
    wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload r5, then reset with a competing WB write and an active load-use condition.
    wb_write(5'd5, 32'h0000_1234);
    @(negedge clk);
    applyStimulus(rtype(5'd5, 5'd7, 5'd1, 6'b100000), 32'h4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("preload_r5", read_data1, 32'h0000_1234);
    @(negedge clk);
    rst = 1'b1;
    wb_reg_write = 1'b1; wb_write_reg = 5'd7; wb_write_data = 32'h0000_0BAD;
    applyStimulus(jtype(6'b000011, {5'd5, 21'd0}), 32'h4, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0);
    #1;
    checkOutput("rst_ctrl", ctrl_word(), {21'd0, C_NONE});
    checkOutput("rst_rd1", read_data1, 32'd0);
    checkOutput("rst_pc_src", {30'd0, pc_src}, 32'd0);
    checkOutput("rst_flush", {31'd0, if_id_flush}, 32'd0);
    checkOutput("rst_pc_write", {31'd0, pc_write}, 32'd1);
    checkOutput("rst_if_id_write", {31'd0, if_id_write}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; wb_reg_write = 1'b0;
    applyStimulus(rtype(5'd5, 5'd7, 5'd1, 6'b100000), 32'h4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("r5_after_rst", read_data1, 32'd0);
    checkOutput("r7_wb_ignored_in_rst", read_data2, 32'd0);

    wb_write(5'd1, 32'h0000_0011);
    wb_write(5'd2, 32'h0000_0022);
    wb_write(5'd6, 32'h0000_0066);
    wb_write(5'd7, 32'h0000_0200);

    // Same-cycle bypass of a WB write, then a WB write to r0.
    @(negedge clk);
    wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_write_data = 32'hDEAD_BEEF;
    applyStimulus(rtype(5'd3, 5'd3, 5'd1, 6'b100000), 32'h8, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("bypass_rd1", read_data1, 32'hDEAD_BEEF);
    checkOutput("bypass_rd2", read_data2, 32'hDEAD_BEEF);
    @(negedge clk);
    wb_write_reg = 5'd0; wb_write_data = 32'h0000_FFFF;
    applyStimulus(rtype(5'd0, 5'd3, 5'd1, 6'b100000), 32'h8, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("r0_bypass", read_data1, 32'd0);
    checkOutput("r3_written", read_data2, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    wb_reg_write = 1'b0;
    #1;
    checkOutput("r0_after_write", read_data1, 32'd0);

    // Register state now: r1=0x11 r2=0x22 r3=0xDEADBEEF r6=0x66 r7=0x200.
    add_vec(rtype(1, 2, 4, 6'b100000), 32'h10, 0, 0, 0, 0, 0, C_ADD, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(1, 2, 4, 6'b100010), 32'h10, 0, 0, 0, 0, 0, C_SUB, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(1, 2, 4, 6'b100100), 32'h10, 0, 0, 0, 0, 0, C_AND, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(1, 2, 4, 6'b100101), 32'h10, 0, 0, 0, 0, 0, C_OR,  M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(1, 2, 4, 6'b101010), 32'h10, 0, 0, 0, 0, 0, C_SLT, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(itype(6'b100011, 1, 2, 16'h0004), 32'h10, 0, 0, 0, 0, 0, C_LW, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(itype(6'b101011, 1, 2, 16'h0004), 32'h10, 0, 0, 0, 0, 0, C_SW, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(itype(6'b001000, 1, 5, 16'hFFFF), 32'h10, 0, 0, 0, 0, 0, C_ADDI, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(itype(6'b001010, 1, 5, 16'h0007), 32'h10, 0, 0, 0, 0, 0, C_SLTI, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(itype(6'b000100, 1, 1, 16'hFFFF), 32'h100, 0, 0, 0, 0, 0, C_NONE, M_WR, 2'b01, 1, 1, 1, 32'h0000_00FC);
    add_vec(itype(6'b000101, 1, 1, 16'h0008), 32'h200, 0, 0, 0, 0, 0, C_NONE, M_WR, 2'b00, 1, 0, 0, 0);
    add_vec(itype(6'b000101, 1, 2, 16'h0008), 32'h200, 0, 0, 0, 0, 0, C_NONE, M_WR, 2'b01, 1, 1, 1, 32'h0000_0220);
    add_vec(itype(6'b000100, 1, 2, 16'h0008), 32'h200, 0, 0, 0, 0, 0, C_NONE, M_WR, 2'b00, 1, 0, 0, 0);
    add_vec(jtype(6'b000010, 26'h010_0000), 32'h0040_0004, 0, 0, 0, 0, 0, C_NONE, M_WR, 2'b10, 1, 1, 1, 32'h0040_0000);
    add_vec(jtype(6'b000011, 26'h000_0040), 32'h8000_0008, 0, 0, 0, 0, 0, C_JAL, M_WR, 2'b10, 1, 1, 1, 32'h8000_0100);
    add_vec(rtype(7, 0, 0, 6'b001000), 32'h10, 0, 0, 0, 0, 0, C_NONE, M_WR, 2'b11, 1, 1, 1, 32'h0000_0200);
    add_vec({6'b111111, 26'h3FF_FFFF}, 32'h10, 0, 0, 0, 0, 0, C_NONE, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(1, 2, 4, 6'b000111), 32'h10, 0, 0, 0, 0, 0, C_NONE, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(2, 6, 4, 6'b100000), 32'h10, 1, 1, 2, 0, 0, C_NONE, M_ALL, 2'b00, 0, 0, 0, 0);
    add_vec(rtype(2, 6, 4, 6'b100000), 32'h10, 1, 1, 6, 0, 0, C_NONE, M_ALL, 2'b00, 0, 0, 0, 0);
    add_vec(itype(6'b001000, 1, 2, 16'h0001), 32'h10, 1, 1, 2, 0, 0, C_ADDI, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(0, 0, 4, 6'b100000), 32'h10, 1, 1, 0, 0, 0, C_ADD, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(itype(6'b000100, 1, 1, 16'hFFFF), 32'h100, 0, 1, 1, 0, 0, C_NONE, M_ALL, 2'b00, 0, 0, 0, 0);
    add_vec(itype(6'b000100, 1, 2, 16'h0008), 32'h100, 0, 0, 0, 1, 2, C_NONE, M_ALL, 2'b00, 0, 0, 0, 0);
    add_vec(itype(6'b000100, 1, 2, 16'h0008), 32'h100, 0, 0, 0, 0, 2, C_NONE, M_WR, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(1, 2, 4, 6'b100000), 32'h10, 0, 1, 1, 0, 0, C_ADD, M_ALL, 2'b00, 1, 0, 0, 0);
    add_vec(rtype(7, 0, 0, 6'b001000), 32'h10, 0, 1, 7, 0, 0, C_NONE, M_ALL, 2'b00, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].instr, vecs[i].pc4, vecs[i].ex_mr, vecs[i].ex_rw, vecs[i].ex_wr,
                    vecs[i].mem_mr, vecs[i].mem_wr);
      #1;
      checkOutput($sformatf("vec%0d ctrl", i), ctrl_word() & {21'd0, vecs[i].mask},
                  {21'd0, vecs[i].ctrl & vecs[i].mask});
      checkOutput($sformatf("vec%0d pc_src", i), {30'd0, pc_src}, {30'd0, vecs[i].src});
      checkOutput($sformatf("vec%0d pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].pcw});
      checkOutput($sformatf("vec%0d if_id_write", i), {31'd0, if_id_write}, {31'd0, vecs[i].pcw});
      checkOutput($sformatf("vec%0d flush", i), {31'd0, if_id_flush}, {31'd0, vecs[i].flush});
      if (vecs[i].chk_t) checkOutput($sformatf("vec%0d target", i), pc_target, vecs[i].target);
    end

    // jal field passthroughs.
    @(negedge clk);
    applyStimulus(jtype(6'b000011, 26'h000_0040), 32'h8000_0008, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("jal_addPC", addPC, 32'h8000_0008);
    applyStimulus(itype(6'b100011, 5'd9, 5'd10, 16'h8004), 32'h10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("lw_sign_extend", sign_extend, 32'hFFFF_8004);
    checkOutput("lw_rs_rt_rd", {17'd0, rs, rt, rd}, {17'd0, 5'd9, 5'd10, 5'd16});

    // Load-use: one bubble cycle, then the held instruction issues.
    @(negedge clk);
    applyStimulus(rtype(5'd2, 5'd6, 5'd4, 6'b100000), 32'h20, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
    #1;
    checkOutput("lu_stall_pc_write", {31'd0, pc_write}, 32'd0);
    checkOutput("lu_stall_if_id_write", {31'd0, if_id_write}, 32'd0);
    checkOutput("lu_stall_reg_write", {31'd0, reg_write}, 32'd0);
    @(negedge clk);
    applyStimulus(rtype(5'd2, 5'd6, 5'd4, 6'b100000), 32'h20, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("lu_release_reg_write", {31'd0, reg_write}, 32'd1);
    checkOutput("lu_release_pc_write", {31'd0, pc_write}, 32'd1);

    // Branch on an EX load: stall with the load in EX, then again in MEM, then resolve.
    @(negedge clk);
    applyStimulus(itype(6'b000100, 5'd1, 5'd2, 16'h0004), 32'h40, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
    #1;
    checkOutput("br_ld_ex_pc_write", {31'd0, pc_write}, 32'd0);
    @(negedge clk);
    applyStimulus(itype(6'b000100, 5'd1, 5'd2, 16'h0004), 32'h40, 1'b0, 1'b0, 5'd0, 1'b1, 5'd2);
    #1;
    checkOutput("br_ld_mem_pc_write", {31'd0, pc_write}, 32'd0);
    checkOutput("br_ld_mem_pc_src", {30'd0, pc_src}, 32'd0);
    @(negedge clk);
    applyStimulus(itype(6'b000101, 5'd1, 5'd2, 16'h0004), 32'h40, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("br_ld_resolve_pc_src", {30'd0, pc_src}, 32'd1);
    checkOutput("br_ld_resolve_target", pc_target, 32'h0000_0050);

    // jr r7 behind an EX ALU write: stall without flush, then redirect.
    @(negedge clk);
    applyStimulus(rtype(5'd7, 5'd0, 5'd0, 6'b001000), 32'h60, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
    #1;
    checkOutput("jr_stall_pc_write", {31'd0, pc_write}, 32'd0);
    checkOutput("jr_stall_flush", {31'd0, if_id_flush}, 32'd0);
    @(negedge clk);
    applyStimulus(rtype(5'd7, 5'd0, 5'd0, 6'b001000), 32'h60, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("jr_pc_src", {30'd0, pc_src}, 32'd3);
    checkOutput("jr_target", pc_target, 32'h0000_0200);
    checkOutput("jr_flush", {31'd0, if_id_flush}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
